// File: rtl/lsu_pkg.sv
// Shared types for the load/store queue: FSM states, entry payload, default widths.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 16;
  localparam int unsigned LSU_DATA_W = 16;
  localparam int unsigned LSU_TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } lsu_state_e;

  // One queued op; fwd marks a load whose data was taken from an older store.
  typedef struct packed {
    logic                  mode;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
    logic [LSU_TAG_W-1:0]  pw;
    logic [LSU_TAG_W-1:0]  tag;
    logic                  fwd;
  } lsu_entry_t;

endpackage

// File: rtl/lsu_fwd_match.sv
// Finds the youngest valid store in the queue whose address equals the incoming load's.
module lsu_fwd_match
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  lsu_entry_t [DEPTH-1:0] ents,
  input  logic [PTR_W-1:0]       head,
  input  logic [CNT_W-1:0]       count,
  input  logic [LSU_ADDR_W-1:0]  addr,
  output logic                   hit,
  output logic [LSU_DATA_W-1:0]  data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && !ents[idx].mode && (ents[idx].addr == addr)) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/lsu_queue.sv
// In-order load/store queue servicing one cache request at a time from the head.
// Optional store-to-load forwarding is built when LSU_FWD_EN is defined.
module lsu_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned TAG_W  = LSU_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_mode,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_data,
  input  logic [TAG_W-1:0]  issue_pw,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_rsp_valid,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_pw,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lsu_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]       head, tail, head_n;
  logic [CNT_W-1:0]       count;
  lsu_state_e             state, state_n;
  lsu_entry_t             head_e, next_e, req_e, enq_e;
  logic                   enq, deq, more, res_rsp, res_fwd;
  logic                   fwd_hit;
  logic [LSU_DATA_W-1:0]  fwd_data;

  assign issue_ready = (count < CNT_W'(DEPTH)) && !flush && (state != DRAIN);
  assign enq         = issue_valid && issue_ready;
  assign head_e      = mem[head];
  assign next_e      = mem[head + PTR_W'(1)];
  assign head_n      = deq ? head + PTR_W'(1) : head;
  assign req_e       = mem[head_n];

`ifdef LSU_FWD_EN
  lsu_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .ents  (mem),
    .head  (head),
    .count (count),
    .addr  (LSU_ADDR_W'(issue_addr)),
    .hit   (fwd_hit),
    .data  (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    enq_e      = '0;
    enq_e.mode = issue_mode;
    enq_e.addr = LSU_ADDR_W'(issue_addr);
    enq_e.data = (issue_mode && fwd_hit) ? fwd_data : LSU_DATA_W'(issue_data);
    enq_e.pw   = LSU_TAG_W'(issue_pw);
    enq_e.tag  = LSU_TAG_W'(issue_tag);
    enq_e.fwd  = issue_mode && fwd_hit;
  end

  // Next-state and dequeue decisions; forwarded heads bypass the cache from IDLE.
  always_comb begin
    state_n = state;
    deq     = 1'b0;
    res_rsp = 1'b0;
    res_fwd = 1'b0;
    more    = (count > CNT_W'(1)) && !next_e.fwd;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head_e.mode && head_e.fwd) begin
            deq     = 1'b1;
            res_fwd = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (dc_req_ready) begin
          if (!head_e.mode) begin
            deq     = 1'b1;
            state_n = more ? REQ : IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (dc_rsp_valid) begin
          deq     = 1'b1;
          res_rsp = 1'b1;
          state_n = more ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (dc_rsp_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A load still owed by the cache must have its response swallowed.
    if (flush) begin
      deq     = 1'b0;
      res_rsp = 1'b0;
      res_fwd = 1'b0;
      if (((state == WAIT) || (state == DRAIN)) && !dc_rsp_valid) state_n = DRAIN;
      else if ((state == REQ) && dc_req_ready && head_e.mode)     state_n = DRAIN;
      else                                                        state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      dc_req_valid <= 1'b0;
      dc_we        <= 1'b0;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      res_valid    <= 1'b0;
      res_pw       <= '0;
      res_tag      <= '0;
      res_data     <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head <= head_n;
        if (enq) tail <= tail + PTR_W'(1);
        if (enq && !deq)      count <= count + CNT_W'(1);
        else if (!enq && deq) count <= count - CNT_W'(1);
      end
      // Request fields reload from the (possibly new) head; unchanged while stalled.
      dc_req_valid <= (state_n == REQ);
      if (state_n == REQ) begin
        dc_we    <= !req_e.mode;
        dc_addr  <= ADDR_W'(req_e.addr);
        dc_wdata <= DATA_W'(req_e.data);
      end
      res_valid <= res_rsp || res_fwd;
      if (res_rsp) begin
        res_data <= dc_rdata;
        res_pw   <= TAG_W'(head_e.pw);
        res_tag  <= TAG_W'(head_e.tag);
      end else if (res_fwd) begin
        res_data <= DATA_W'(head_e.data);
        res_pw   <= TAG_W'(head_e.pw);
        res_tag  <= TAG_W'(head_e.tag);
      end
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// Self-checking bench for lsu_queue: vector table, directed corner sequences, random vs model.
module tb_lsu_queue;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_ready, issue_mode;
  logic [15:0] issue_addr, issue_data;
  logic [4:0]  issue_pw, issue_tag;
  logic        dc_req_valid, dc_req_ready, dc_we, dc_rsp_valid, res_valid;
  logic [15:0] dc_addr, dc_wdata, dc_rdata, res_data;
  logic [4:0]  res_pw, res_tag;

  int total = 0;
  int bad   = 0;

  lsu_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(16), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_mode(issue_mode),
    .issue_addr(issue_addr), .issue_data(issue_data), .issue_pw(issue_pw), .issue_tag(issue_tag),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_rsp_valid(dc_rsp_valid), .dc_rdata(dc_rdata),
    .res_valid(res_valid), .res_pw(res_pw), .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mode;
    logic [15:0] addr;
    logic [15:0] data;
    logic [4:0]  pw;
    logic [4:0]  tag;
    int          delay;
    logic [15:0] rdata;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct { logic [15:0] addr; logic [15:0] data; } st_t;
  typedef struct { logic [4:0] pw; logic [4:0] tag; logic [15:0] val; } ld_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; issue_valid = 1'b0; issue_mode = 1'b0; issue_addr = '0; issue_data = '0;
    issue_pw = '0; issue_tag = '0; dc_req_ready = 1'b0; dc_rsp_valid = 1'b0; dc_rdata = '0;
  endtask

  task automatic issue(input logic mode, input logic [15:0] addr, input logic [15:0] data,
                       input logic [4:0] pw, input logic [4:0] tag);
    issue_valid = 1'b1; issue_mode = mode; issue_addr = addr; issue_data = data;
    issue_pw = pw; issue_tag = tag;
    #1;
    check("issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!dc_req_valid && n < 10) begin
      tick();
      n++;
    end
    check("req_seen", 32'(dc_req_valid), 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    dc_req_ready = 1'b1;
    issue(v.mode, v.addr, v.data, v.pw, v.tag);
    wait_req();
    check("dc_we", 32'(dc_we), 32'(v.exp_we));
    check("dc_addr", 32'(dc_addr), 32'(v.exp_addr));
    if (!v.mode) check("dc_wdata", 32'(dc_wdata), 32'(v.exp_wdata));
    tick();
    check("req_one_cycle", 32'(dc_req_valid), 32'd0);
    if (!v.mode) begin
      check("count_empty", 32'(dut.count), 32'd0);
    end else begin
      dc_req_ready = 1'b0;
      for (int i = 0; i < v.delay; i++) begin
        check("res_early", 32'(res_valid), 32'd0);
        tick();
      end
      dc_rsp_valid = 1'b1; dc_rdata = v.rdata;
      tick();
      dc_rsp_valid = 1'b0;
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_pw", 32'(res_pw), 32'(v.pw));
      check("res_tag", 32'(res_tag), 32'(v.tag));
      check("res_data", 32'(res_data), 32'(v.exp_res));
      tick();
      check("res_one_cycle", 32'(res_valid), 32'd0);
      check("count_empty", 32'(dut.count), 32'd0);
    end
    dc_req_ready = 1'b0;
  endtask

  vec_t vecs[5];
  logic [15:0] cmem[8];
  logic [15:0] mmem[8];
  st_t stq[$];
  ld_t ldq[$];

  initial begin
    vecs[0] = '{1'b0, 16'h0010, 16'h1234, 5'd0,  5'd0, 0, 16'h0000, 1'b1, 16'h0010, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 16'h0040, 16'h0000, 5'd7,  5'd3, 4, 16'hBEEF, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 5'd1,  5'd2, 0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 16'h0000, 16'h0000, 5'd31, 5'd0, 0, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[4] = '{1'b1, 16'h8001, 16'h0000, 5'd16, 5'd31, 1, 16'h7FFF, 1'b0, 16'h8001, 16'h0000, 16'h7FFF};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    check("rst_req_valid", 32'(dc_req_valid), 32'd0);
    check("rst_dc_we", 32'(dc_we), 32'd0);
    check("rst_dc_addr", 32'(dc_addr), 32'd0);
    check("rst_dc_wdata", 32'(dc_wdata), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_fields", {12'd0, res_data, res_pw, res_tag}, 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Full queue with a stalled cache: fifth op refused, request held stable.
    dc_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_mode = 1'b0;
      issue_addr = 16'h0100 + 16'(i); issue_data = 16'h0A00 + 16'(i);
      #1;
      check($sformatf("full_ready_%0d", i), 32'(issue_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    issue_valid = 1'b0;
    check("full_count", 32'(dut.count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(dc_req_valid), 32'd1);
      check("stall_addr", 32'(dc_addr), 32'h0100);
      tick();
    end
    dc_req_ready = 1'b1;
    #1;
    check("full_deq_ready", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(dc_req_valid), 32'd1);
      check("drain_addr", 32'(dc_addr), 32'h0100 + 32'(i));
      check("drain_wdata", 32'(dc_wdata), 32'h0A00 + 32'(i));
      tick();
    end
    check("drain_done", 32'(dc_req_valid), 32'd0);
    check("drain_count", 32'(dut.count), 32'd0);

    // Flush in WAIT, late response swallowed in DRAIN.
    dc_req_ready = 1'b1;
    issue(1'b1, 16'h0030, 16'h0000, 5'd2, 5'd1);
    wait_req();
    tick();
    dc_req_ready = 1'b0; flush = 1'b1;
    #1;
    check("flush_ready", 32'(issue_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("drain_res", 32'(res_valid), 32'd0);
    check("drain_blocks", 32'(issue_ready), 32'd0);
    tick();
    check("drain_blocks2", 32'(issue_ready), 32'd0);
    dc_rsp_valid = 1'b1; dc_rdata = 16'hDEAD;
    tick();
    dc_rsp_valid = 1'b0;
    check("swallow_res", 32'(res_valid), 32'd0);
    check("drain_exit", 32'(issue_ready), 32'd1);
    tick();
    check("swallow_res2", 32'(res_valid), 32'd0);
    run_op(vecs[1]);

    // Flush while a request is stalled in REQ.
    issue(1'b1, 16'h0044, 16'h0000, 5'd5, 5'd6);
    wait_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_req_drop", 32'(dc_req_valid), 32'd0);
    check("flush_req_ready", 32'(issue_ready), 32'd1);
    check("flush_req_count", 32'(dut.count), 32'd0);

    // Reset mid-WAIT: no DRAIN afterwards.
    dc_req_ready = 1'b1;
    issue(1'b1, 16'h0050, 16'h0000, 5'd4, 5'd4);
    wait_req();
    tick();
    dc_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_wait_ready", 32'(issue_ready), 32'd1);
    check("rst_wait_valid", 32'(dc_req_valid), 32'd0);
    run_op(vecs[3]);

`ifdef LSU_FWD_EN
    begin
      int reqs = 0;
      int n = 0;
      dc_req_ready = 1'b0;
      issue(1'b0, 16'h0020, 16'h00AA, 5'd0, 5'd0);
      issue(1'b1, 16'h0020, 16'h0000, 5'd9, 5'd8);
      dc_req_ready = 1'b1;
      while (!res_valid && n < 12) begin
        #1;
        if (dc_req_valid && dc_req_ready) reqs++;
        tick();
        n++;
      end
      check("fwd_res_valid", 32'(res_valid), 32'd1);
      check("fwd_res_data", 32'(res_data), 32'h00AA);
      check("fwd_res_pw", 32'(res_pw), 32'd9);
      check("fwd_res_tag", 32'(res_tag), 32'd8);
      check("fwd_req_count", 32'(reqs), 32'd1);
      dc_req_ready = 1'b0;
      tick();
    end
`endif

    // Random traffic against a program-order memory model.
    begin
      bit          rsp_pend = 1'b0;
      int          rsp_cnt  = 0;
      logic [15:0] rsp_data = '0;
      for (int i = 0; i < 8; i++) begin
        cmem[i] = 16'h5000 + 16'(i);
        mmem[i] = 16'h5000 + 16'(i);
      end
      for (int cyc = 0; cyc < 700; cyc++) begin
        issue_valid  = (cyc < 300) && ($urandom_range(0, 2) != 0);
        issue_mode   = 1'($urandom_range(0, 1));
        issue_addr   = 16'($urandom_range(0, 7));
        issue_data   = 16'($urandom);
        issue_pw     = 5'($urandom);
        issue_tag    = 5'($urandom);
        dc_req_ready = (cyc >= 300) || ($urandom_range(0, 1) == 1);
        dc_rsp_valid = 1'b0;
        if (rsp_pend && rsp_cnt == 0) begin
          dc_rsp_valid = 1'b1;
          dc_rdata     = rsp_data;
          rsp_pend     = 1'b0;
        end else if (rsp_pend) begin
          rsp_cnt--;
        end
        #1;
        if (issue_valid && issue_ready) begin
          if (!issue_mode) begin
            stq.push_back('{issue_addr, issue_data});
            mmem[issue_addr[2:0]] = issue_data;
          end else begin
            ldq.push_back('{issue_pw, issue_tag, mmem[issue_addr[2:0]]});
          end
        end
        if (dc_req_valid && dc_req_ready) begin
          if (dc_we) begin
            if (stq.size() == 0) begin
              check("rnd_store_unexpected", 32'd1, 32'd0);
            end else begin
              check("rnd_store_addr", 32'(dc_addr), 32'(stq[0].addr));
              check("rnd_store_data", 32'(dc_wdata), 32'(stq[0].data));
              void'(stq.pop_front());
            end
            cmem[dc_addr[2:0]] = dc_wdata;
          end else begin
            rsp_pend = 1'b1;
            rsp_cnt  = $urandom_range(0, 3);
            rsp_data = cmem[dc_addr[2:0]];
          end
        end
        tick();
        if (res_valid) begin
          if (ldq.size() == 0) begin
            check("rnd_res_unexpected", 32'd1, 32'd0);
          end else begin
            check("rnd_res_pw", 32'(res_pw), 32'(ldq[0].pw));
            check("rnd_res_tag", 32'(res_tag), 32'(ldq[0].tag));
            check("rnd_res_data", 32'(res_data), 32'(ldq[0].val));
            void'(ldq.pop_front());
          end
        end
      end
      check("rnd_stores_left", 32'(stq.size()), 32'd0);
      check("rnd_loads_left", 32'(ldq.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
